// File: rtl/pulse_gen_multi.sv
`timescale 1ns/1ps
// pulse_gen_multi
// Multi-channel edge-to-pulse generator. Each channel synchronises an
// asynchronous event line and detects the globally selected edge type. It
// then emits a registered pulse whose width is programmable at runtime,
// optionally followed by a forced low gap. A per-channel sticky flag records
// edges that could neither start nor extend a pulse.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   sig            asynchronous event inputs, one bit per channel
//   edge_mode      00 rising, 01 falling, 10 both edges, 11 disabled
//   pulse_width    pulse length in cycles (0 behaves as 1)
//   retrigger      1: an edge during a pulse reloads the count; 0: edge is flagged
//   clear_overrun  synchronous per-channel clear of the overrun flag
//   pulse          registered pulse outputs
//   busy           high while a channel is in PULSE or GAP
//   overrun        sticky per-channel overrun flags
module pulse_gen_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH_BITS  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sig,
  input  logic [1:0]            edge_mode,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic                  retrigger,
  input  logic [CHANNELS-1:0]   clear_overrun,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   overrun
);

  // The gap counter is sized for GAP_CYCLES-1 and kept at least one bit wide
  // so the design still elaborates when the gap is disabled.
  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_BITS-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_BITS'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width 0 is treated as 1, so both load a count of zero.
  logic [WIDTH_BITS-1:0] load_val;
  assign load_val = (pulse_width == '0) ? '0 : pulse_width - WIDTH_BITS'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   trig;
    state_t                 state_q, state_d;
    logic [WIDTH_BITS-1:0]  cnt_q, cnt_d;
    logic [GAP_BITS-1:0]    gap_q, gap_d;
    logic                   retrig_q, retrig_d;
    logic                   ovr_q, ovr_d;

    // Synchroniser chain plus edge-history flop; a line held high through
    // reset release therefore looks like a rising edge.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q[0] <= sig[i];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
        hist_q <= s;
      end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~hist_q;
    assign fall = ~s & hist_q;

    // Trigger selection follows edge_mode live, with no latching.
    always_comb begin
      trig = 1'b0;
      case (edge_mode)
        2'b00:   trig = rise;
        2'b01:   trig = fall;
        2'b10:   trig = rise | fall;
        default: trig = 1'b0;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        gap_q    <= '0;
        retrig_q <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        gap_q    <= gap_d;
        retrig_q <= retrig_d;
        ovr_q    <= ovr_d;
      end
    end

    // retrigger is captured together with the width at each load, so a change
    // mid-pulse never alters how the running pulse behaves. A reload wins over
    // the cnt==0 exit, and an overrun set wins over a simultaneous clear.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      retrig_d = retrig_q;
      ovr_d    = ovr_q & ~clear_overrun[i];
      case (state_q)
        IDLE: begin
          if (trig) begin
            cnt_d    = load_val;
            retrig_d = retrigger;
            state_d  = PULSE;
          end
        end
        PULSE: begin
          if (trig && retrig_q) begin
            cnt_d    = load_val;
            retrig_d = retrigger;
          end else begin
            if (trig) begin
              ovr_d = 1'b1;
            end
            if (cnt_q == '0) begin
              if (GAP_CYCLES > 0) begin
                gap_d   = GAP_LOAD;
                state_d = GAP;
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - WIDTH_BITS'(1);
            end
          end
        end
        GAP: begin
          if (trig) begin
            ovr_d = 1'b1;
          end
          if (gap_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q - GAP_BITS'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    assign pulse[i]   = (state_q == PULSE);
    assign busy[i]    = (state_q != IDLE);
    assign overrun[i] = ovr_q;
  end

endmodule
